// File: rtl/can_frame_sequencer.sv
// Transmit sequencer for the CAN data-frame path: steps the field blocks in
// order, handles arbitration loss and errors, and retries failed frames.
module can_frame_sequencer #(
  parameter int MAX_RETRIES = 3,
  parameter int IFS_BITS    = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sample_point,
  input  logic       tx_request,
  input  logic [3:0] dlc,
  input  logic       sof_complete,
  input  logic       arb_complete,
  input  logic       ctrl_complete,
  input  logic       data_complete,
  input  logic       crc_complete,
  input  logic       ack_complete,
  input  logic       eof_complete,
  input  logic       arb_lost,
  input  logic       error_detected,
  output logic [7:0] field_en,
  output logic [3:0] dlc_latched,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_failed,
  output logic [2:0] retry_count
);

  typedef enum logic [3:0] {
    IDLE, SOF, ARB, CTRL, DATA, CRC, ACK, EOF, IFS
  } state_t;

  state_t     state;
  logic [2:0] ifs_count;
  logic       success;
  logic       drop;

  // NOTE: every register below uses non-blocking assignments so all state
  // updates on the same edge see the pre-edge values of each other.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dlc_latched <= '0;
      tx_done     <= 1'b0;
      tx_failed   <= 1'b0;
      retry_count <= '0;
      ifs_count   <= '0;
      success     <= 1'b0;
      drop        <= 1'b0;
    end else begin
      tx_done   <= 1'b0;
      tx_failed <= 1'b0;
      unique case (state)
        IDLE: begin
          // A dropped frame blocks new starts until the host releases tx_request.
          if (drop) begin
            if (!tx_request) drop <= 1'b0;
          end else if (sample_point && tx_request) begin
            state       <= SOF;
            dlc_latched <= dlc;
          end
        end
        IFS: begin
          if (sample_point) begin
            if (ifs_count == 3'(IFS_BITS - 1)) begin
              state     <= IDLE;
              ifs_count <= '0;
              if (success) begin
                tx_done     <= 1'b1;
                retry_count <= '0;
              end else if (retry_count > 3'(MAX_RETRIES)) begin
                tx_failed   <= 1'b1;
                retry_count <= '0;
                drop        <= 1'b1;
              end
            end else begin
              ifs_count <= ifs_count + 3'd1;
            end
          end
        end
        default: begin
          if (error_detected) begin
            state     <= IFS;
            ifs_count <= '0;
            success   <= 1'b0;
            if (retry_count != 3'd7) retry_count <= retry_count + 3'd1;
          end else if (arb_lost && state == ARB) begin
            state     <= IFS;
            ifs_count <= '0;
            success   <= 1'b0;
          end else begin
            unique case (state)
              SOF:  if (sof_complete)  state <= ARB;
              ARB:  if (arb_complete)  state <= CTRL;
              CTRL: if (ctrl_complete) state <= (dlc_latched == 4'd0) ? CRC : DATA;
              DATA: if (data_complete) state <= CRC;
              CRC:  if (crc_complete)  state <= ACK;
              ACK:  if (ack_complete)  state <= EOF;
              EOF: begin
                if (eof_complete) begin
                  state     <= IFS;
                  ifs_count <= '0;
                  success   <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // NOTE: defaulting field_en before the case keeps this purely combinational.
  always_comb begin
    field_en = '0;
    unique case (state)
      SOF:     field_en = 8'h01;
      ARB:     field_en = 8'h02;
      CTRL:    field_en = 8'h04;
      DATA:    field_en = 8'h08;
      CRC:     field_en = 8'h10;
      ACK:     field_en = 8'h20;
      EOF:     field_en = 8'h40;
      IFS:     field_en = 8'h80;
      default: field_en = '0;
    endcase
  end

  assign tx_busy = (state != IDLE);

endmodule
